// File: rtl/sig_mul_norm.sv
// Sequential significand multiplier with normalisation for the float multiply path.
// Shift-add over NSIG+1 cycles, one normalise cycle, then a held result until accepted.
module sig_mul_norm #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NSIG-1:0]     sigA,
  input  logic [NSIG-1:0]     sigB,
  input  logic                aZero,
  input  logic                bZero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*NSIG+1:0]   pSig,
  output logic                expInc
);

  localparam int PW = 2 * NSIG + 2;
  localparam int CW = $clog2(NSIG + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // The exponent width only keeps the parameter set uniform with its neighbours.
  if (NEXP < 1) begin : g_bad_nexp
    $error("sig_mul_norm: NEXP must be positive");
  end

  logic [1:0]    state;
  logic [NSIG:0] mcand;
  logic [NSIG:0] mplier;
  logic          zero;
  logic [PW-1:0] acc;
  logic [PW-1:0] addend;
  logic [CW-1:0] cnt;

  // Handshake: a transfer happens on any posedge where valid && ready; the
  // sender holds valid and data until that edge, and ready never depends on valid.
  assign in_ready = (state == IDLE);

  assign addend = {{(NSIG + 1){1'b0}}, mcand} << cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      zero      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      pSig      <= '0;
      expInc    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {1'b1, sigA};
            mplier <= {1'b1, sigB};
            zero   <= aZero | bZero;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + addend;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(NSIG)) state <= NORM;
        end
        NORM: begin
          // Product of two values in [1,2) lies in [1,4): at most one left shift.
          if (zero) begin
            pSig   <= '0;
            expInc <= 1'b0;
          end else if (acc[PW-1]) begin
            pSig   <= acc;
            expInc <= 1'b1;
          end else begin
            pSig   <= {acc[PW-2:0], 1'b0};
            expInc <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_mul_norm.sv
// Directed bench for sig_mul_norm: reset, products, zero operands, back-pressure,
// back-to-back operations and reset in the middle of a multiply.
module tb_sig_mul_norm;

  localparam int NSIG = 7;
  localparam int PW   = 2 * NSIG + 2;
  localparam int LAT  = NSIG + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NSIG-1:0] sigA = '0;
  logic [NSIG-1:0] sigB = '0;
  logic          aZero = 1'b0;
  logic          bZero = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] pSig;
  logic          expInc;

  int total = 0;
  int bad   = 0;

  sig_mul_norm #(.NEXP(8), .NSIG(NSIG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sigA(sigA), .sigB(sigB), .aZero(aZero), .bZero(bZero),
    .out_valid(out_valid), .out_ready(out_ready), .pSig(pSig), .expInc(expInc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation, checks latency and result, then drains it.
  task automatic run_op(input logic [NSIG-1:0] a, input logic [NSIG-1:0] b,
                        input logic az, input logic bz,
                        input logic [PW-1:0] exp_p, input logic exp_e,
                        input string name);
    int k;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s idle in_ready got=%b want=1", name, in_ready);
    end
    sigA = a; sigB = b; aZero = az; bZero = bz; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    sigA = ~a; sigB = ~b; aZero = 1'b0; bZero = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL %s busy in_ready got=%b want=0", name, in_ready);
    end
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    total++;
    if (k != LAT) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", name, k, LAT);
    end
    total++;
    if (pSig !== exp_p) begin
      bad++; $display("FAIL %s pSig got=%h want=%h", name, pSig, exp_p);
    end
    total++;
    if (expInc !== exp_e) begin
      bad++; $display("FAIL %s expInc got=%b want=%b", name, expInc, exp_e);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s drain out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || pSig !== '0 || expInc !== 1'b0) begin
      bad++;
      $display("FAIL reset in_ready=%b out_valid=%b pSig=%h expInc=%b want 1/0/0000/0",
               in_ready, out_valid, pSig, expInc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_products();
    run_op(7'h00, 7'h00, 1'b0, 1'b0, 16'h8000, 1'b0, "one_x_one");
    run_op(7'h40, 7'h40, 1'b0, 1'b0, 16'h9000, 1'b1, "1p5_sq");
    run_op(7'h7F, 7'h7F, 1'b0, 1'b0, 16'hFE01, 1'b1, "max_sq");
    run_op(7'h00, 7'h40, 1'b0, 1'b0, 16'hC000, 1'b0, "one_x_1p5");
    run_op(7'h20, 7'h10, 1'b0, 1'b0, 16'hB400, 1'b0, "mixed");
    run_op(7'h7F, 7'h00, 1'b0, 1'b0, 16'hFF00, 1'b0, "max_x_one");
  endtask

  task automatic test_zero();
    run_op(7'h55, 7'h2A, 1'b1, 1'b0, 16'h0000, 1'b0, "a_zero");
    run_op(7'h7F, 7'h7F, 1'b0, 1'b1, 16'h0000, 1'b0, "b_zero");
  endtask

  task automatic test_backpressure();
    int k;
    sigA = 7'h40; sigB = 7'h40; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    total++;
    if (k != LAT) begin
      bad++; $display("FAIL bp latency got=%0d want=%0d", k, LAT);
    end
    sigA = 7'h7F; sigB = 7'h7F; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || pSig !== 16'h9000 || expInc !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp hold%0d out_valid=%b pSig=%h expInc=%b in_ready=%b want 1/9000/1/0",
                 i, out_valid, pSig, expInc, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pSig !== 16'h9000) begin
      bad++;
      $display("FAIL bp release out_valid=%b in_ready=%b pSig=%h want 0/1/9000",
               out_valid, in_ready, pSig);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp no_accept out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    run_op(7'h7F, 7'h7F, 1'b0, 1'b0, 16'hFE01, 1'b1, "b2b_first");
    run_op(7'h00, 7'h00, 1'b0, 1'b0, 16'h8000, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    sigA = 7'h7F; sigB = 7'h7F; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pSig !== '0 || expInc !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid out_valid=%b in_ready=%b pSig=%h expInc=%b want 0/1/0000/0",
               out_valid, in_ready, pSig, expInc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL rst_mid quiet%0d out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
    run_op(7'h40, 7'h40, 1'b0, 1'b0, 16'h9000, 1'b1, "after_rst");
  endtask

  initial begin
    test_reset();
    test_products();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
